// File: rtl/inc_stream.sv
// Streaming +1 stage: each accepted word is incremented modulo 2^WIDTH and queued
// in a DEPTH-entry FIFO toward a valid/ready output, with a delivered-word counter.
module inc_stream #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  // Each entry holds {carry, sum}; storage is deliberately not reset.
  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     occ;
  logic            push;
  logic            pop;
  logic [WIDTH:0]  inc_word;

  // in_ready depends only on occupancy, so a pop while full never frees a slot
  // for a push in the same cycle.
  assign in_ready  = (occ != OCC_FULL);
  assign out_valid = (occ != '0);
  assign full      = (occ == OCC_FULL);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign inc_word = {1'b0, in_data} + (WIDTH+1)'(1);

  assign {out_carry, out_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= inc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_inc_stream.sv
// Self-checking bench for inc_stream: random and directed stimulus, a queue-based
// reference model of the FIFO, and a monitor comparing every handshake and status.
module tb_inc_stream;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             full;

  int n_cmp = 0;
  int n_err = 0;

  inc_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_ready (out_ready),
    .count     (count),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected FIFO contents as (data, carry) pairs and a
  // plain integer delivered count.
  int exp_data_q[$];
  int exp_carry_q[$];
  int cnt_model = 0;
  bit armed = 0;

  // Monitor samples late in the low phase, just before the rising edge.
  initial begin
    int sz;
    int v;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        exp_data_q.delete();
        exp_carry_q.delete();
        cnt_model = 0;
        armed = 1;
      end else if (armed) begin
        sz = exp_data_q.size();
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("in_ready", 32'(in_ready), 32'(sz != DEPTH));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("count", 32'(count), 32'(cnt_model % (1 << CNT_W)));
        if (sz != 0 && out_ready) begin
          check("out_data", 32'(out_data), 32'(exp_data_q.pop_front()));
          check("out_carry", 32'(out_carry), 32'(exp_carry_q.pop_front()));
          cnt_model++;
        end
        if (in_valid && sz != DEPTH) begin
          v = int'(in_data) + 1;
          exp_data_q.push_back(v % (1 << WIDTH));
          exp_carry_q.push_back((v >= (1 << WIDTH)) ? 1 : 0);
        end
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge that
  // follows the accepting rising edge.
  task automatic send(input logic [WIDTH-1:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_count", 32'(count), 0);
    check("idle_in_ready", 32'(in_ready), 1);

    // Exhaustive transform
    out_ready = 1'b1;
    for (int d = 0; d < 4; d++) send(WIDTH'(d));
    repeat (2) @(negedge clk);
    check("exhaustive_count", 32'(count), 4);

    // Round trip with decrementer outputs 11,00,01,10
    send(2'b11); send(2'b00); send(2'b01); send(2'b10);
    repeat (2) @(negedge clk);
    check("roundtrip_count", 32'(count), 8);

    // Fill and backpressure
    out_ready = 1'b0;
    send(2'b00); send(2'b01); send(2'b10); send(2'b11);
    check("fill_full", 32'(full), 1);
    check("fill_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 2'b00;
    @(negedge clk);
    check("blocked_full", 32'(full), 1);
    check("blocked_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    send(2'b00);
    repeat (6) @(negedge clk);
    check("fill_count", 32'(count), 13);

    // Randomized traffic
    repeat (300) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("random_drained", 32'(out_valid), 0);

    // Count wrap: 257 words from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) send(WIDTH'($urandom));
    repeat (3) @(negedge clk);
    check("wrap_count", 32'(count), 1);

    // Reset mid-stream with occ=3
    out_ready = 1'b0;
    send(2'b01); send(2'b10); send(2'b11);
    check("pre_reset_valid", 32'(out_valid), 1);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 2'b10;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("midreset_out_valid", 32'(out_valid), 0);
    check("midreset_count", 32'(count), 0);
    check("midreset_full", 32'(full), 0);
    check("midreset_in_ready", 32'(in_ready), 1);
    repeat (3) @(negedge clk);
    check("midreset_lost", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inc_stream.md
# inc_stream

Streaming increment stage: the inverse of the team's 2-bit decrement transform. It accepts words over a valid/ready handshake and adds 1 modulo 2^WIDTH, so that out = in + 1 restores what the decrementer removed. Results pass through a DEPTH-entry FIFO to a valid/ready output. A running count of delivered words is kept for the testbench's results dump. The block sits after the decrement DUT in round-trip benches; a word passed through both must come back unchanged.

## Interface
- WIDTH, 2, data word width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 8, width of the delivered-word counter
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous and active-low
- in_valid  input  1  upstream word present
- in_data  input  WIDTH  upstream word
- in_ready  output  1  block can accept a word this cycle
- out_valid  output  1  FIFO head valid
- out_data  output  WIDTH  head word, (in_data + 1) mod 2^WIDTH
- out_carry  output  1  head word wrapped: its input was all ones
- out_ready  input  1  downstream accepts head
- count  output  CNT_W  words delivered since reset, mod 2^CNT_W
- full  output  1  FIFO holds DEPTH entries

## Operation
- Push: in_valid && in_ready.
  - Store {carry, sum} at the write pointer, where {carry, sum} = in_data + 1 computed at WIDTH+1 bits.
  - Advance the write pointer.
- Pop: out_valid && out_ready.
  - Advance the read pointer.
  - Increment count; count wraps from 2^CNT_W−1 to 0.
- Occupancy register occ, 0..DEPTH:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Pointers are log2(DEPTH) bits and wrap from DEPTH−1 to 0 naturally.
- in_ready = (occ != DEPTH). No pass-through when full: a pop while full does not enable a push in the same cycle.
- out_valid = (occ != 0). out_data and out_carry are read from the FIFO head.
- full = (occ == DEPTH).
- Data with in_valid=0 is ignored. out_data and out_carry are don't-care while out_valid=0; the bench does not check them then.
- Order is strictly preserved; there is no drop and no duplication.
- The block has no state machine beyond the FIFO. Its only states are empty (occ=0), partial, and full (occ=DEPTH).

## Timing
- Reset: when rst_n=0 at a rising edge, the next state is occ=0, pointers=0, count=0. Storage contents are not reset.
  - Resulting outputs: in_ready=1, out_valid=0, full=0, count=0.
- Reset mid-operation discards all held words. Any push or pop in that cycle is ignored.
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N, provided the FIFO was empty. Minimum latency is 1 cycle; there is no combinational in→out path.
- Sustained throughput is 1 word/cycle when out_ready is held high and occ is between 1 and DEPTH−1.
- Simultaneous push and pop at occ=0: the push happens and the pop is impossible, since out_valid=0.
- Simultaneous push and pop at occ=DEPTH: the pop happens and the push is blocked. occ becomes DEPTH−1, so in_ready=1 the next cycle.
- Downstream must hold out_ready independently of in_valid. The block holds out_data stable while out_valid=1 and no pop occurs.
- count updates on the edge of the pop, so a new value is visible the cycle after the handshake.

## Test plan
- Reset then idle:
  - rst_n=0 for 2 cycles, then 1 with in_valid=0.
  - Required: in_ready=1, out_valid=0, full=0, count=0 throughout.
- Exhaustive transform, out_ready=1:
  - Push 00, 01, 10, 11 on consecutive cycles.
  - Required: out_data 01, 10, 11, 00 one cycle after each push; out_carry 0, 0, 0, 1; count ends at 4.
- Round trip with the decrement DUT:
  - Feed DUT outputs 11, 00, 01, 10 (its results for inputs 00..11).
  - Required: out_data 00, 01, 10, 11.
- Fill and backpressure:
  - out_ready=0, push 5 words 00, 01, 10, 11, 00.
  - Required: in_ready=0 and full=1 after the 4th push; the 5th word is not accepted.
  - Then set out_ready=1 with in_valid still high. Required: pops give 01, 10, 11, 00. The 5th word is accepted only in the cycle after the first pop. Its result is 01.
- Count wrap:
  - Deliver 257 words with CNT_W=8.
  - Required: count reads 255 then 0 then 1.
- Reset mid-stream:
  - With occ=3, assert rst_n=0 while in_valid=1 and out_ready=1.
  - Required: on the next cycle occ=0, out_valid=0, count=0; the pushed word is lost.
